// File: rtl/core_pkg.sv
// Shared core types: ALU opcodes, forwarding selects
// and writeback source encodings.
package core_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

endpackage

// File: rtl/forward_mux.sv
// 3:1 operand forwarding mux; the unused code 11
// falls back to the register-file value.
module forward_mux
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] reg_val,
  input  logic [DATA_WIDTH-1:0] wb_val,
  input  logic [DATA_WIDTH-1:0] mem_val,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = reg_val;
    case (fwd_sel_t'(sel))
      FWD_WB:  y = wb_val;
      FWD_MEM: y = mem_val;
      default: y = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with bubble/stall
// handling and forwarding onto the execute ALU operands.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CONTROL_WIDTH  = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      ValidD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [CONTROL_WIDTH-1:0]  ALUControlD,
  input  logic                      ALUSrcD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      BranchD,
  input  logic                      JumpD,
  input  logic [1:0]                ForwardAE,
  input  logic [1:0]                ForwardBE,
  input  logic [DATA_WIDTH-1:0]     ALUResultM,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [DATA_WIDTH-1:0]     SrcAE,
  output logic [DATA_WIDTH-1:0]     SrcBE,
  output logic [CONTROL_WIDTH-1:0]  ALUControlE,
  output logic [DATA_WIDTH-1:0]     WriteDataE,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      BranchE,
  output logic                      JumpE,
  output logic [1:0]                ResultSrcE,
  output logic                      ValidE
);

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [CONTROL_WIDTH-1:0]  aluctl;
    logic                      alusrc;
    logic                      regwrite;
    logic                      memwrite;
    logic [1:0]                resultsrc;
    logic                      branch;
    logic                      jump;
  } ex_t;

  ex_t q;
  ex_t nxt;

  // An all-zero record is the bubble; ALU op 000 is ADD.
  always_comb begin
    nxt = '0;
    if (ValidD) begin
      nxt.valid     = 1'b1;
      nxt.rd1       = RD1D;
      nxt.rd2       = RD2D;
      nxt.imm       = ImmExtD;
      nxt.pc        = PCD;
      nxt.rs1       = Rs1D;
      nxt.rs2       = Rs2D;
      nxt.rd        = RdD;
      nxt.aluctl    = ALUControlD;
      nxt.alusrc    = ALUSrcD;
      nxt.regwrite  = RegWriteD & (RdD != '0);
      nxt.memwrite  = MemWriteD;
      nxt.resultsrc = ResultSrcD;
      nxt.branch    = BranchD;
      nxt.jump      = JumpD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (FlushE) begin
      q <= '0;
    end else if (!StallE) begin
      q <= nxt;
    end
  end

  logic [DATA_WIDTH-1:0] fwd_b;

  forward_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
    .sel     (ForwardAE),
    .reg_val (q.rd1),
    .wb_val  (ResultW),
    .mem_val (ALUResultM),
    .y       (SrcAE)
  );

  forward_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
    .sel     (ForwardBE),
    .reg_val (q.rd2),
    .wb_val  (ResultW),
    .mem_val (ALUResultM),
    .y       (fwd_b)
  );

  assign WriteDataE  = fwd_b;
  assign SrcBE       = q.alusrc ? q.imm : fwd_b;
  assign ALUControlE = q.aluctl;
  assign ImmExtE     = q.imm;
  assign PCE         = q.pc;
  assign Rs1E        = q.rs1;
  assign Rs2E        = q.rs2;
  assign RdE         = q.rd;
  assign RegWriteE   = q.regwrite;
  assign MemWriteE   = q.memwrite;
  assign BranchE     = q.branch;
  assign JumpE       = q.jump;
  assign ResultSrcE  = q.resultsrc;
  assign ValidE      = q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model of the
// E-stage contents checked every cycle plus literal checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE, ValidD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
  logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] SrcAE, SrcBE, WriteDataE, ImmExtE, PCE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
  logic [1:0]  ResultSrcE;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .ResultSrcD(ResultSrcD), .BranchD(BranchD), .JumpD(JumpD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .ImmExtE(ImmExtE), .PCE(PCE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ValidE(ValidE)
  );

  int passed = 0;
  int total  = 0;
  bit checking = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Model: what the E slot holds, by instruction fields.
  typedef struct {
    bit        v;
    bit [31:0] rd1, rd2, imm, pc;
    bit [4:0]  rs1, rs2, rd;
    bit [2:0]  ctl;
    bit        asrc, rw, mw, br, j;
    bit [1:0]  rs;
  } mdl_t;

  mdl_t m = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || FlushE) m <= '{default: 0};
    else if (!StallE) begin
      if (ValidD)
        m <= '{v: 1'b1, rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD,
               rs1: Rs1D, rs2: Rs2D, rd: RdD, ctl: ALUControlD,
               asrc: ALUSrcD, rw: RegWriteD && (RdD != 0),
               mw: MemWriteD, br: BranchD, j: JumpD, rs: ResultSrcD};
      else
        m <= '{default: 0};
    end
  end

  function automatic bit [31:0] fwd(bit [1:0] s, bit [31:0] r);
    if (s == 2'd1) return ResultW;
    if (s == 2'd2) return ALUResultM;
    return r;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      bit [31:0] wd;
      wd = fwd(ForwardBE, m.rd2);
      chk("m.SrcAE", SrcAE, fwd(ForwardAE, m.rd1));
      chk("m.WriteDataE", WriteDataE, wd);
      chk("m.SrcBE", SrcBE, m.asrc ? m.imm : wd);
      chk("m.ALUControlE", {29'd0, ALUControlE}, {29'd0, m.ctl});
      chk("m.ImmExtE", ImmExtE, m.imm);
      chk("m.PCE", PCE, m.pc);
      chk("m.idx", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, m.rs1, m.rs2, m.rd});
      chk("m.ctl", {25'd0, ValidE, RegWriteE, MemWriteE, BranchE, JumpE,
                    ResultSrcE},
                   {25'd0, m.v, m.rw, m.mw, m.br, m.j, m.rs});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_idle();
    ValidD = 1'b1; RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; ALUControlD = 3'b000;
    ALUSrcD = 0; RegWriteD = 0; MemWriteD = 0; ResultSrcD = 0;
    BranchD = 0; JumpD = 0;
  endtask

  initial begin
    rst_n = 1'b0; StallE = 0; FlushE = 0;
    ForwardAE = 0; ForwardBE = 0; ALUResultM = 0; ResultW = 0;
    d_idle();
    tick(); tick();
    checking = 1;
    chk("reset.ValidE", {31'd0, ValidE}, 32'd0);
    chk("reset.ALUControlE", {29'd0, ALUControlE}, 32'd0);
    rst_n = 1'b1;

    // Load with immediate operand B
    RD1D = 32'h5; ImmExtD = 32'hFFFF_FFF0; ALUSrcD = 1;
    ALUControlD = 3'b001; PCD = 32'h10;
    tick();
    chk("load.SrcAE", SrcAE, 32'h5);
    chk("load.SrcBE", SrcBE, 32'hFFFF_FFF0);
    chk("load.ALUControlE", {29'd0, ALUControlE}, 32'd1);
    chk("load.ValidE", {31'd0, ValidE}, 32'd1);

    // Forwarding on A and B while stalled
    d_idle();
    RD1D = 32'h1; RD2D = 32'h22; ALUControlD = 3'b011;
    tick();
    StallE = 1;
    ForwardAE = 2'b10; ALUResultM = 32'hABCD; #1;
    chk("fwdA.mem", SrcAE, 32'hABCD);
    ForwardAE = 2'b01; ResultW = 32'h1234; #1;
    chk("fwdA.wb", SrcAE, 32'h1234);
    ForwardAE = 2'b11; #1;
    chk("fwdA.rsvd", SrcAE, 32'h1);
    ForwardBE = 2'b10; #1;
    chk("fwdB.mem", SrcBE, 32'hABCD);
    chk("fwdB.wd", WriteDataE, 32'hABCD);
    ForwardBE = 2'b01; tick();
    chk("fwdB.stall", SrcBE, 32'h1234);
    ForwardAE = 0; ForwardBE = 0; StallE = 0;

    // Stall holds through three changing D values
    d_idle();
    PCD = 32'h100; RD1D = 32'h77; RdD = 5'd9; RegWriteD = 1;
    tick();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      PCD = 32'h200 + i; RD1D = 32'h80 + i; RdD = 5'd10 + i[4:0];
      tick();
      chk("stall.PCE", PCE, 32'h100);
      chk("stall.SrcAE", SrcAE, 32'h77);
    end
    StallE = 0; PCD = 32'h300;
    tick();
    chk("release.PCE", PCE, 32'h300);
    chk("release.RdE", {27'd0, RdE}, 32'd12);

    // Flush wins over stall
    d_idle();
    PCD = 32'h44; RegWriteD = 1; MemWriteD = 1; RdD = 5'd7;
    tick();
    chk("preflush.RegWriteE", {31'd0, RegWriteE}, 32'd1);
    FlushE = 1; StallE = 1;
    tick();
    chk("flush.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("flush.MemWriteE", {31'd0, MemWriteE}, 32'd0);
    chk("flush.ValidE", {31'd0, ValidE}, 32'd0);
    chk("flush.PCE", PCE, 32'd0);
    FlushE = 0; StallE = 0;

    // x0 write suppression
    d_idle();
    RegWriteD = 1; RdD = 5'd0;
    tick();
    chk("x0.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("x0.ValidE", {31'd0, ValidE}, 32'd1);
    RdD = 5'd5;
    tick();
    chk("x5.RegWriteE", {31'd0, RegWriteE}, 32'd1);

    // Invalid decode slot captures as a bubble
    ValidD = 0; PCD = 32'h55;
    tick();
    chk("bubble.ValidE", {31'd0, ValidE}, 32'd0);
    chk("bubble.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("bubble.PCE", PCE, 32'd0);

    // Asynchronous reset mid-cycle
    d_idle();
    RD1D = 32'h9; RegWriteD = 1; RdD = 5'd3; ALUControlD = 3'b100;
    PCD = 32'h88;
    tick();
    chk("prerst.RegWriteE", {31'd0, RegWriteE}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("arst.ValidE", {31'd0, ValidE}, 32'd0);
    chk("arst.SrcAE", SrcAE, 32'd0);
    chk("arst.PCE", PCE, 32'd0);
    chk("arst.ALUControlE", {29'd0, ALUControlE}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage RISC-V core.
- Latches decoded operands, immediate, PC and control from decode.
- Applies hazard-unit stall/flush.
- Resolves operand forwarding to drive SrcA, SrcB and ALUControl of the execute-stage ALU directly.

Parameters:
DATA_WIDTH, 32, width of register data, immediate and PC
CONTROL_WIDTH, 3, width of ALU control code (matches ALU)
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
StallE  input  1  hold current E-stage contents
FlushE  input  1  load bubble into E stage
ValidD  input  1  decode slot holds a real instruction
RD1D  input  DATA_WIDTH  rs1 read data
RD2D  input  DATA_WIDTH  rs2 read data
ImmExtD  input  DATA_WIDTH  extended immediate
PCD  input  DATA_WIDTH  instruction PC
Rs1D  input  REG_ADDR_WIDTH  rs1 index
Rs2D  input  REG_ADDR_WIDTH  rs2 index
RdD  input  REG_ADDR_WIDTH  rd index
ALUControlD  input  CONTROL_WIDTH  ALU operation
ALUSrcD  input  1  1 = SrcB from immediate
RegWriteD  input  1  writes rd
MemWriteD  input  1  store
ResultSrcD  input  2  writeback source select
BranchD  input  1  conditional branch
JumpD  input  1  jump
ForwardAE  input  2  SrcA forward select
ForwardBE  input  2  rs2 forward select
ALUResultM  input  DATA_WIDTH  memory-stage ALU result
ResultW  input  DATA_WIDTH  writeback-stage result
SrcAE  output  DATA_WIDTH  ALU operand A
SrcBE  output  DATA_WIDTH  ALU operand B
ALUControlE  output  CONTROL_WIDTH  ALU operation
WriteDataE  output  DATA_WIDTH  forwarded rs2 (store data)
ImmExtE, PCE  output  DATA_WIDTH  latched immediate / PC
Rs1E, Rs2E, RdE  output  REG_ADDR_WIDTH  latched indices (to hazard unit)
RegWriteE, MemWriteE, BranchE, JumpE  output  1  latched control
ResultSrcE  output  2  latched writeback select
ValidE  output  1  E slot holds a real instruction

Behaviour:
- Reset, asynchronous on rst_n low:
  - All registers clear to 0, so ValidE=0, all control 0 and ALUControlE=ADD (000).
  - Combinational outputs then follow the zeroed state: SrcAE=0, SrcBE=0, WriteDataE=0.
- Registers update on clk rising edge only when rst_n is high. Priority: FlushE > StallE > load.
- FlushE=1:
  - Bubble: ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE cleared.
  - Datapath fields (RD1, RD2, Imm, PC, indices) cleared to 0; ALUControlE=ADD.
  - Overrides StallE when both are asserted.
- StallE=1 with FlushE=0: every register holds its value.
- Load:
  - All D fields are captured.
  - ValidD=0 captures as a bubble, same as flush.
  - RegWriteE captured as RegWriteD & (RdD != 0): writes to x0 are suppressed here.
- Latency: exactly 1 cycle D->E.
- Forwarding is combinational on the latched values, within the cycle:
  - ForwardAE: 00 -> latched RD1; 01 -> ResultW; 10 -> ALUResultM; 11 -> latched RD1 (reserved).
  - ForwardBE selects WriteDataE with the same encoding over the latched RD2.
- SrcBE = ALUSrc ? ImmExtE : WriteDataE. The latched ALUSrc is an internal register.
- During a stall, forwarded values may change cycle-to-cycle as M/W advance; SrcAE and SrcBE track them.
- No width extension: all data paths are DATA_WIDTH; no arithmetic is performed in this block.

Decomposition:
- Shared package core_pkg:
  - alu_op_t enum (ADD=000, SUB=001, AND=010, OR=011, XOR=100); ALU and this block both use it.
  - fwd_sel_t enum (FWD_REG=00, FWD_WB=01, FWD_MEM=10).
  - RESULT_SRC encodings.
- Sub-module forward_mux (3:1 with reserved code, DATA_WIDTH parameter), instantiated twice (A and B).

Test Plan:
1. rst_n low mid-operation with RegWriteE=1 -> all outputs 0 immediately (asynchronously, before next edge); ALUControlE=000.
2. Load RD1D=0x5, ImmExtD=0xFFFFFFF0, ALUSrcD=1, ALUControlD=001, Forward=00 -> next cycle SrcAE=0x5, SrcBE=0xFFFFFFF0, ALUControlE=001, ValidE=1.
3. Latched RD1=0x1, ForwardAE=10 with ALUResultM=0xABCD, then 01 with ResultW=0x1234, then 11 -> SrcAE=0xABCD, then 0x1234, then 0x1.
4. StallE=1 for 3 cycles while D inputs change every cycle -> E outputs hold the original instruction; first cycle after release captures the then-current D value.
5. FlushE=1 and StallE=1 together with RegWriteE=1, MemWriteE=1 held -> next edge RegWriteE=0, MemWriteE=0, ValidE=0, PCE=0.
6. RegWriteD=1 with RdD=0 -> RegWriteE=0, ValidE=1; RdD=5 -> RegWriteE=1.
